gpio_in_conditioner: RTL and testbench
======================================

# gpio_in_conditioner

Input conditioning stage for the GPIO read path. It takes raw asynchronous pad or switch levels, synchronises and debounces each bit, and detects edges on the filtered level. Its filtered levels and sticky edge flags feed the CPU-readable PIO inputs (`gpio_*_r`, the KEY/SW bits of the bank C read word). It sits between the tristate pad logic and the Qsys PIO read ports, in the 25 MHz `clk25` domain.

## Interface
Parameters:
- `WIDTH`, 32: number of conditioned bits.
- `SYNC_STAGES`, 2: synchroniser flops per bit; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, 250: cycles a new level must persist before it is accepted (10 µs at 25 MHz); legal range ≥ 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; derived, not overridden.

Ports:
- `clk`, in, 1: system clock (`clk25`).
- `reset`, in, 1: **one clock; reset is synchronous and active-high.**
- `pin_i`, in, `WIDTH`: raw asynchronous input levels.
- `filt_o`, out, `WIDTH`: debounced level.
- `rise_o`, out, `WIDTH`: one-cycle pulse on a 0→1 change of `filt_o`.
- `fall_o`, out, `WIDTH`: one-cycle pulse on a 1→0 change of `filt_o`.
- `flag_o`, out, `WIDTH`: sticky per-bit edge flag (either polarity).
- `clear_i`, in, `WIDTH`: write-one-to-clear for `flag_o`, level-sampled every cycle.

## Operation
- **Sync chain:** `SYNC_STAGES` flops per bit. Stage 0 samples `pin_i`. `s` is the last stage's output.
- **Debounce, per bit:**
  - If `s == filt`, `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`, then `filt <= s` and `cnt <= 0`.
  - Otherwise, `cnt <= cnt + 1`.
  - Any return of `s` to `filt` before acceptance restarts the count from 0, so glitches shorter than `DEBOUNCE_CYCLES` are fully rejected.
  - The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap.
- **Edges:** `rise_o`/`fall_o` are registered. They assert in the same cycle that `filt_o` shows its new value, for exactly one cycle.
- **Flags:** `flag <= (flag & ~clear_i) | rise | fall`, using the same-cycle edge pulses.
  - If set and clear coincide, set wins.
  - Clearing a bit with no pending edge has no effect.
- **Reset:** all outputs and internal state go to 0 in the cycle after `reset` is sampled high: sync flops, `cnt`, `filt_o`, `rise_o`, `fall_o`, `flag_o`.
  - Reset mid-count discards the count.
  - After reset, a pin held high produces a normal rise (pulse and flag) after the full latency.
- Bits are fully independent. Simultaneous edges on several bits all report in the same cycle.

## Timing
- **Latency:** a clean level change on `pin_i`, first sampled at edge k, appears on `filt_o`/`rise_o`/`fall_o` after edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1.
  - Defaults: 251 cycles.
  - With `SYNC_STAGES`=2 and `DEBOUNCE_CYCLES`=4: 5 edges after first sampling.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` cycles at `s`. Anything shorter produces no output activity.
- **Flag set:** `flag_o` rises one cycle after the edge pulse. `clear_i` takes effect on the next edge.
- **Throughput:** a new edge can be reported at most once every `DEBOUNCE_CYCLES` cycles per bit.
- No combinational path from any input to any output.

## Structure
- **Package `gpio_pkg`:**
  - `GPIO_DEBOUNCE_DEFAULT` = 250.
  - `GPIO_SYNC_DEFAULT` = 2.
  - `CLK_HZ` = 25_000_000.
  - A `cycles_from_us()` constant function, so the top level derives `DEBOUNCE_CYCLES` from a time.
- **Sub-module `gpio_debounce_bit`:** one bit's sync chain, counter, `filt`, edge and flag logic. `gpio_in_conditioner` instantiates `WIDTH` copies of it in a generate loop; the parent is wiring only.
- Top-level integration:
  - Bank A/B/C reads take `filt_o`.
  - `flag_o` maps to a spare PIO read word.
  - `clear_i` comes from a PIO write word.

## Test plan
All scenarios use `WIDTH`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.

1. **Reset:** drive `pin_i`=4'hF and hold `reset` for 3 cycles.
   - During reset, all outputs are 0.
   - After release, `filt_o`=4'hF exactly 5 edges after the first post-reset sample.
   - `rise_o`=4'hF for one cycle; `flag_o`=4'hF one cycle later.
2. **Glitch rejection:** with `filt_o[0]`=0, pulse `pin_i[0]` high for 3 cycles.
   - `filt_o`, `rise_o` and `flag_o` stay 0.
   - A 4-cycle pulse produces `filt_o[0]`=1 followed by a fall.
3. **Bounce:** toggle `pin_i[1]` 1/0 every 2 cycles for 20 cycles, then hold it at 1.
   - Exactly one `rise_o[1]` pulse, 5 edges after the final transition.
   - No `fall_o[1]` pulse.
4. **Flag set/clear collision:** set `flag_o[2]`, then assert `clear_i[2]` in the same cycle as a new `fall_o[2]`.
   - `flag_o[2]` remains 1.
   - The next `clear_i[2]` alone clears it to 0.
5. **Independence:** change bits 0 and 3 on the same edge.
   - Both pulses appear in the same cycle.
   - Bits 1 and 2 show no activity.
6. **Reset mid-count:** assert `reset` for 1 cycle while `cnt`=2 on a pending rise.
   - No pulse is produced.
   - The full 5-edge latency restarts after reset.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and timing helpers for the GPIO input path
package gpio_pkg;
  localparam int CLK_HZ = 25_000_000;
  localparam int GPIO_SYNC_DEFAULT = 2;
  localparam int GPIO_DEBOUNCE_DEFAULT = 250;
  function automatic int cycles_from_us(input int us);
    return CLK_HZ / 1_000_000 * us;
  endfunction
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: one bit of sync, debounce, edge detect and sticky flag
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  input  logic clear,
  output logic filt,
  output logic rise,
  output logic fall,
  output logic flag
);
  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic s;
  logic done;
  assign s = sync[SYNC_STAGES-1];
  // a mismatch that has persisted for the full window is accepted this edge
  assign done = (s != filt) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
      flag <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pin};
      cnt  <= (s == filt || done) ? '0 : cnt + 1'b1;
      filt <= done ? s : filt;
      rise <= done & s;
      fall <= done & ~s;
      flag <= (flag & ~clear) | rise | fall;
    end
  end
endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: per-bit synchronise, debounce and edge-flag GPIO inputs
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SYNC_STAGES = GPIO_SYNC_DEFAULT,
  parameter int DEBOUNCE_CYCLES = cycles_from_us(10)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] filt_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] flag_o,
  input  logic [WIDTH-1:0] clear_i
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W(CNT_W)
    ) u_bit (
      .clk(clk),
      .reset(reset),
      .pin(pin_i[i]),
      .clear(clear_i[i]),
      .filt(filt_o[i]),
      .rise(rise_o[i]),
      .fall(fall_o[i]),
      .flag(flag_o[i])
    );
  end
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed and random checks against a pin-history model
module tb_gpio_in_conditioner;
  localparam int S = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] pin, clr, filt, rise, fall, flag;
  int errors = 0;
  int checks = 0;
  logic [3:0] hist[$];
  logic [3:0] m_filt, m_rise, m_fall, m_flag;
  logic [3:0] act, rc, fc, cur;
  gpio_in_conditioner #(.WIDTH(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .pin_i(pin),
    .filt_o(filt),
    .rise_o(rise),
    .fall_o(fall),
    .flag_o(flag),
    .clear_i(clr)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] s_at(input int m);
    return (m >= S) ? hist[m-S] : 4'h0;
  endfunction
  // accept a new level once the synchronised pin has held it for D post-reset edges
  task automatic model(input logic [3:0] p, input logic [3:0] c, input logic r);
    int n;
    logic [3:0] t, nr, nf;
    logic v, acc;
    if (r) begin
      hist.delete();
      {m_filt, m_rise, m_fall, m_flag} = '0;
      return;
    end
    hist.push_back(p);
    n = hist.size() - 1;
    m_flag = (m_flag & ~c) | m_rise | m_fall;
    nr = '0;
    nf = '0;
    for (int b = 0; b < 4; b++) begin
      t = s_at(n);
      v = t[b];
      acc = (v != m_filt[b]);
      for (int j = 0; j < D; j++) begin
        if (n - j < 0) acc = 1'b0;
        else begin
          t = s_at(n - j);
          if (t[b] != v) acc = 1'b0;
        end
      end
      if (acc) begin
        m_filt[b] = v;
        nr[b] = v;
        nf[b] = ~v;
      end
    end
    m_rise = nr;
    m_fall = nf;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [3:0] p, input logic [3:0] c, input logic r);
    pin = p;
    clr = c;
    reset = r;
    @(posedge clk);
    model(p, c, r);
    #1;
    chk("filt", filt, m_filt);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("flag", flag, m_flag);
  endtask
  initial begin
    // reset with pins high, then the full-latency rise
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 4'h0, 1'b1);
      chk("rst_out", filt | rise | fall | flag, 4'h0);
    end
    for (int i = 1; i <= 7; i++) begin
      step(4'hF, 4'h0, 1'b0);
      if (i < 6) chk("s1_filt_early", filt, 4'h0);
      if (i == 6) chk("s1_filt", filt, 4'hF);
      if (i == 6) chk("s1_rise", rise, 4'hF);
      if (i == 7) chk("s1_flag", flag, 4'hF);
      if (i == 7) chk("s1_rise_once", rise, 4'h0);
    end
    // glitch rejection on bit 0
    for (int i = 0; i < 10; i++) step(4'h0, 4'hF, 1'b0);
    act = '0;
    for (int i = 0; i < 3; i++) begin
      step(4'h1, 4'h0, 1'b0);
      act |= {filt[0], rise[0], fall[0], flag[0]};
    end
    for (int i = 0; i < 8; i++) begin
      step(4'h0, 4'h0, 1'b0);
      act |= {filt[0], rise[0], fall[0], flag[0]};
    end
    chk("s2_glitch", act, 4'h0);
    act = '0;
    for (int i = 0; i < 4; i++) begin
      step(4'h1, 4'h0, 1'b0);
      act[0] |= filt[0];
    end
    for (int i = 0; i < 10; i++) begin
      step(4'h0, 4'h0, 1'b0);
      act[0] |= filt[0];
      act[1] |= fall[0];
    end
    chk("s2_pulse4", act, 4'h3);
    for (int i = 0; i < 2; i++) step(4'h0, 4'hF, 1'b0);
    // bounce on bit 1
    rc = '0;
    fc = '0;
    for (int i = 0; i < 20; i++) begin
      step(((i / 2) % 2 == 0) ? 4'h2 : 4'h0, 4'h0, 1'b0);
      rc += 4'(rise[1]);
      fc += 4'(fall[1]);
    end
    for (int i = 1; i <= 8; i++) begin
      step(4'h2, 4'h0, 1'b0);
      rc += 4'(rise[1]);
      fc += 4'(fall[1]);
      if (i == 6) chk("s3_rise_at5", rise, 4'h2);
    end
    chk("s3_rise_cnt", rc, 4'h1);
    chk("s3_fall_cnt", fc, 4'h0);
    // set/clear collision on bit 2
    for (int i = 0; i < 8; i++) step(4'h6, 4'h0, 1'b0);
    for (int i = 1; i <= 6; i++) step(4'h2, 4'h0, 1'b0);
    chk("s4_fall", fall, 4'h4);
    step(4'h2, 4'h4, 1'b0);
    chk("s4_set_wins", flag & 4'h4, 4'h4);
    step(4'h2, 4'h4, 1'b0);
    chk("s4_clear", flag & 4'h4, 4'h0);
    // simultaneous edges on bits 0 and 3
    act = '0;
    for (int i = 1; i <= 7; i++) begin
      step(4'hB, 4'h0, 1'b0);
      act |= (rise | fall) & 4'h6;
      if (i == 6) chk("s5_rise", rise, 4'h9);
    end
    chk("s5_quiet", act, 4'h0);
    // reset while bit 2 is mid-count
    for (int i = 0; i < 4; i++) step(4'hF, 4'h0, 1'b0);
    step(4'hF, 4'h0, 1'b1);
    chk("s6_rst", filt | rise | fall | flag, 4'h0);
    act = '0;
    for (int i = 1; i <= 6; i++) begin
      step(4'hF, 4'h0, 1'b0);
      if (i < 6) act |= rise | filt;
      if (i == 6) chk("s6_rise", rise, 4'hF);
    end
    chk("s6_no_early", act, 4'h0);
    // random pins, clears and occasional resets
    cur = 4'hF;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) cur = 4'($urandom);
      step(cur, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, $urandom_range(0, 99) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
